bcd_to_binary_seq: RTL and testbench
====================================

BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

Interface
REQ-001 Parameter: BIN_W, 8, binary result width; only 8 is supported, and ITER = BIN_W.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a conversion; sampled only in IDLE.
REQ-005 Port: hundreds  input  2  BCD hundreds digit (0..2).
REQ-006 Port: tens  input  4  BCD tens digit (0..9).
REQ-007 Port: ones  input  4  BCD ones digit (0..9).
REQ-008 Port: bin  output  8  registered binary result, held until the next accepted start.
REQ-009 Port: busy  output  1  high whenever state != IDLE.
REQ-010 Port: done  output  1  registered one-cycle completion pulse.
REQ-011 Port: err  output  1  registered invalid-input flag, valid while done=1 and held until the next accepted start.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at edge k, the block SHALL capture {hundreds,tens,ones} into a 10-bit BCD register, clear the 8-bit shift register and the iteration counter, and clear err.
REQ-014 Validation at edge k: the input is invalid if tens>9, ones>9, hundreds=3, or the value exceeds 255.
REQ-015 Invalid input at edge k SHALL move the FSM to DONE, set err=1 and bin=0; no SHIFT cycles occur, so done=1 in the cycle following edge k.
REQ-016 Valid input at edge k SHALL move the FSM to SHIFT.
REQ-017 Each SHIFT edge SHALL perform one reverse double-dabble step:
- shift {bcd,bin_shift} right by 1;
- then subtract 3 from each of the tens and ones digits whose post-shift value is >= 8;
- the hundreds digit receives 0 in its MSB and needs no correction.
REQ-018 SHIFT SHALL last exactly 8 edges (k+1..k+8); at edge k+8 bin SHALL load the final shift register and the FSM SHALL enter DONE.
REQ-019 done SHALL be 1 only in the DONE state (the cycle after edge k+8 for valid input); the next edge SHALL return the FSM to IDLE.
REQ-020 Total latency for valid input: done high 8 cycles after the start edge; for invalid input, 1 cycle.
REQ-021 start while busy=1 (SHIFT or DONE) SHALL be ignored, with no effect on state, bin or err.
REQ-022 start held high continuously SHALL start a new conversion on the first IDLE edge after DONE, so back-to-back conversions are separated by one IDLE cycle.
REQ-023 Digit inputs SHALL be ignored except at the accepting edge; changes during SHIFT SHALL not affect the result.
REQ-024 All arithmetic SHALL be unsigned, with no overflow possible for validated inputs.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously) force the FSM to IDLE and set bin=0, busy=0, done=0, err=0, and clear all internal registers.
REQ-026 Reset mid-SHIFT SHALL abort the conversion with no done pulse; the first start after reset deasserts SHALL convert normally.

Structure
REQ-027 Shared package bcd_pkg SHALL hold:
- the state enum {IDLE, SHIFT, DONE};
- the constants BIN_W=8, ITER=8, BCD_MAX=255, DIGIT_MAX=9.
REQ-028 One sub-module, bcd_digit_adjust (4-bit in, 4-bit out, subtracts 3 when the input is >= 8, otherwise passes through), SHALL be instantiated twice: once for tens, once for ones.
REQ-029 The iteration counter SHALL be 3 bits wide and count 0..7.

Verification
REQ-030 Input 2,5,5 -> done 8 cycles after start, bin=8'hFF, err=0, busy high for 9 cycles.
REQ-031 Inputs 0,0,0 -> bin=8'h00; 1,2,8 -> bin=8'h80; 0,4,2 -> bin=8'h2A; each with err=0.
REQ-032 Input 2,5,6 -> done the cycle after start, err=1, bin=0; separately, tens=4'hA -> err=1.
REQ-033 start pulsed again at cycle 3 of a conversion of 0,9,9 -> that start is ignored and exactly one done occurs, with bin=8'h63.
REQ-034 rst asserted mid-SHIFT of 1,0,0 -> all outputs 0 in the same cycle and no done; a new start of 0,1,7 -> bin=8'h11.
REQ-035 Exhaustive sweep of values 0..255 with start held high SHALL show bin equal to the decimal value every time and err=0 throughout.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BIN_W     = 8;
  localparam int ITER      = 8;
  localparam int BCD_MAX   = 255;
  localparam int DIGIT_MAX = 9;
  localparam int BCD_W     = 10;
  localparam int CNT_W     = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  function automatic logic [BCD_W-1:0] bcd_value(
    input logic [1:0] h,
    input logic [3:0] t,
    input logic [3:0] o
  );
    return BCD_W'(h) * BCD_W'(100) + BCD_W'(t) * BCD_W'(10) + BCD_W'(o);
  endfunction

  // Digits above 9 or a total above 255 cannot be represented in the result.
  function automatic logic bcd_is_valid(
    input logic [1:0] h,
    input logic [3:0] t,
    input logic [3:0] o
  );
    return (t <= 4'(DIGIT_MAX)) && (o <= 4'(DIGIT_MAX)) && (h != 2'd3) &&
           (bcd_value(h, t, o) <= BCD_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: subtract 3 from a shifted BCD digit that reached 8 or more.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD (000..255) to binary converter: one reverse double-dabble
// shift/adjust step per clock, ITER steps per conversion.
module bcd_to_binary_seq #(
  parameter int BIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import bcd_pkg::*;

  // state | meaning
  // IDLE  | waiting for start; digits captured and validated on the accepting edge
  // SHIFT | one shift/adjust step per edge, ITER edges in total
  // DONE  | done=1 for one cycle; bin/err valid and held afterwards

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   shr_q, shr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [1:0]         hun_sh;
  logic [3:0]         ten_sh, one_sh;
  logic [3:0]         ten_adj, one_adj;
  logic [BIN_W-1:0]   shr_sh;
  logic               in_valid;

  // Right shift of {hundreds, tens, ones, shr}: each digit's LSB falls into the next lower field.
  assign hun_sh = {1'b0, bcd_q[9]};
  assign ten_sh = {bcd_q[8], bcd_q[7:5]};
  assign one_sh = {bcd_q[4], bcd_q[3:1]};
  assign shr_sh = {bcd_q[0], shr_q[BIN_W-1:1]};

  bcd_digit_adjust u_adj_tens (
    .digit_i (ten_sh),
    .digit_o (ten_adj)
  );

  bcd_digit_adjust u_adj_ones (
    .digit_i (one_sh),
    .digit_o (one_adj)
  );

  assign in_valid = bcd_is_valid(hundreds, tens, ones);

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    shr_d   = shr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d = {hundreds, tens, ones};
          shr_d = '0;
          cnt_d = '0;
          err_d = 1'b0;
          if (in_valid) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            bin_d   = '0;
            done_d  = 1'b1;
          end
        end
      end

      SHIFT: begin
        bcd_d = {hun_sh, ten_adj, one_adj};
        shr_d = shr_sh;
        if (cnt_q == CNT_LAST) begin
          bin_d   = shr_sh;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      shr_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      shr_q   <= shr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bin  = bin_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed table, corner sequences,
// randomized conversions against a decimal reference model, and a held-start sweep.
module tb_bcd_to_binary_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int h;
    int t;
    int o;
    int exp_bin;
    int exp_err;
  } vec_t;

  vec_t vecs[12];

  bcd_to_binary_seq #(.BIN_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Decimal meaning of the three digits; anything unrepresentable yields err=1, bin=0.
  function automatic void ref_model(input int h, input int t, input int o,
                                    output int b, output int e);
    int v;
    v = h * 100 + t * 10 + o;
    if (t > 9 || o > 9 || h > 2 || v > 255) begin
      b = 0;
      e = 1;
    end else begin
      b = v;
      e = 0;
    end
  endfunction

  task automatic issue(input int h, input int t, input int o);
    @(negedge clk);
    hundreds = 2'(h);
    tens     = 4'(t);
    ones     = 4'(o);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge. Records which later edge raised done,
  // how many done samples and busy samples occurred. poke_at >= 0 pulses
  // start with scrambled digits for one cycle at that point of the conversion.
  task automatic observe(input int poke_at, output int done_at, output int done_n,
                         output int busy_n, output int b, output int e);
    int edges;
    edges   = 0;
    done_at = -1;
    done_n  = 0;
    busy_n  = 0;
    b       = 0;
    e       = 0;
    while (busy && edges < 40) begin
      busy_n++;
      if (done) begin
        done_n++;
        done_at = edges;
        b = int'(bin);
        e = int'(err);
      end
      if (poke_at >= 0 && edges == poke_at) begin
        start    = 1'b1;
        hundreds = 2'($urandom_range(0, 3));
        tens     = 4'($urandom_range(0, 15));
        ones     = 4'($urandom_range(0, 15));
      end else if (poke_at >= 0 && edges == poke_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    check("busy_returns_low", int'(edges < 40), 1);
  endtask

  task automatic check_conv(input string name, input int h, input int t, input int o,
                            input int exp_b, input int exp_e, input int poke_at);
    int done_at, done_n, busy_n, b, e;
    issue(h, t, o);
    observe(poke_at, done_at, done_n, busy_n, b, e);
    start = 1'b0;
    check($sformatf("%s bin", name), b, exp_b);
    check($sformatf("%s err", name), e, exp_e);
    check($sformatf("%s done_edge", name), done_at, (exp_e != 0) ? 0 : 8);
    check($sformatf("%s done_count", name), done_n, 1);
    check($sformatf("%s busy_cycles", name), busy_n, (exp_e != 0) ? 1 : 9);
  endtask

  initial begin
    int b_exp, e_exp, h, t, o, v, seen;
    int done_at, done_n, busy_n, b, e;

    vecs[0]  = '{2, 5, 5, 255, 0};
    vecs[1]  = '{0, 0, 0, 0, 0};
    vecs[2]  = '{1, 2, 8, 128, 0};
    vecs[3]  = '{0, 4, 2, 42, 0};
    vecs[4]  = '{2, 5, 6, 0, 1};
    vecs[5]  = '{0, 10, 0, 0, 1};
    vecs[6]  = '{0, 0, 10, 0, 1};
    vecs[7]  = '{3, 0, 0, 0, 1};
    vecs[8]  = '{2, 6, 0, 0, 1};
    vecs[9]  = '{1, 9, 9, 199, 0};
    vecs[10] = '{2, 0, 0, 200, 0};
    vecs[11] = '{0, 0, 1, 1, 0};

    rst      = 1'b1;
    start    = 1'b0;
    hundreds = 2'd0;
    tens     = 4'd0;
    ones     = 4'd0;
    #12;
    check("reset bin", int'(bin), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      check_conv($sformatf("vec%0d", i), vecs[i].h, vecs[i].t, vecs[i].o,
                 vecs[i].exp_bin, vecs[i].exp_err, -1);

    // A start pulse in the third cycle of a conversion must be ignored.
    check_conv("ignore_start", 0, 9, 9, 99, 0, 2);

    // Asynchronous reset in the middle of SHIFT aborts with no done pulse.
    issue(1, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midreset bin", int'(bin), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset err", int'(err), 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("midreset no_done", seen, 0);
    check_conv("after_reset", 0, 1, 7, 17, 0, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom_range(0, 255);
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
      end else begin
        h = $urandom_range(0, 3);
        t = $urandom_range(0, 15);
        o = $urandom_range(0, 15);
      end
      ref_model(h, t, o, b_exp, e_exp);
      check_conv($sformatf("rand%0d_%0d_%0d_%0d", n, h, t, o), h, t, o, b_exp, e_exp,
                 (e_exp != 0) ? -1 : $urandom_range(0, 6));
    end

    // Held start: every value converts back-to-back with one IDLE cycle between.
    @(negedge clk);
    hundreds = 2'd0;
    tens     = 4'd0;
    ones     = 4'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    for (int val = 0; val < 256; val++) begin
      observe(-1, done_at, done_n, busy_n, b, e);
      check($sformatf("sweep%0d bin", val), b, val);
      check($sformatf("sweep%0d err", val), e, 0);
      check($sformatf("sweep%0d done_edge", val), done_at, 8);
      if (val < 255) begin
        hundreds = 2'((val + 1) / 100);
        tens     = 4'(((val + 1) / 10) % 10);
        ones     = 4'((val + 1) % 10);
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
